sqrt_share_ctrl: RTL

Round-robin scheduler that shares one fixed-latency, non-stallable polynomial square-root unit between two requester channels (A, B) in the noise generator. It accepts 31-bit operands over valid/ready handshakes and issues at most one operand per cycle to the unit. It tracks each in-flight operation's channel tag through a latency pipe and returns each 17-bit result (4 integer + 13 fraction bits) to the owning channel through a per-channel output FIFO. Per-channel credits guarantee that no result is ever dropped, because the sqrt unit cannot be stalled.

---
 rtl/noise_pkg.sv | 21 ++
 rtl/sqrt_resp_fifo.sv | 69 ++++++
 rtl/sqrt_share_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/noise_pkg.sv
// Shared definitions for the noise generator's square-root path:
// operand/result widths, channel identifiers and the in-flight tag record.
package noise_pkg;

  localparam int SQRT_IN_W   = 31;
  localparam int SQRT_OUT_W  = 17;
  localparam int SQRT_FRAC_W = 13;

  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } chan_t;

  typedef struct packed {
    logic  valid;
    chan_t chan;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, chan: CH_A};

endpackage

// File: rtl/sqrt_resp_fifo.sv
// First-word fall-through result FIFO with an occupancy count; the head data
// reads as zero while empty so the output never shows stale storage.
module sqrt_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 17,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic          out_valid_o,
  output logic [W-1:0]  out_data_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1'b1);
  endfunction

  // Head/pop decode
  always_comb begin
    pop_s       = pop_i && (cnt_q != '0);
    out_valid_o = (cnt_q != '0);
    count_o     = cnt_q;
    if (cnt_q != '0) begin
      out_data_o = mem_q[rd_q];
    end else begin
      out_data_o = '0;
    end
  end

  // Storage array, written at the tail
  always_ff @(posedge clock) begin
    if (push_i) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        wr_q <= ptr_inc(wr_q);
      end
      if (pop_s) begin
        rd_q <= ptr_inc(rd_q);
      end
      case ({push_i, pop_s})
        2'b10:   cnt_q <= cnt_q + CW'(1'b1);
        2'b01:   cnt_q <= cnt_q - CW'(1'b1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sqrt_share_ctrl.sv
// Round-robin sharing of one fixed-latency, non-stallable sqrt unit between
// channels A and B; credits reserve FIFO space before issue so no result drops.
module sqrt_share_ctrl
  import noise_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [SQRT_IN_W-1:0]  a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [SQRT_IN_W-1:0]  b_data,
  output logic [SQRT_IN_W-1:0]  sq_din,
  input  logic [SQRT_OUT_W-1:0] sq_dout,
  output logic                  a_out_valid,
  input  logic                  a_out_ready,
  output logic [SQRT_OUT_W-1:0] a_out_data,
  output logic                  b_out_valid,
  input  logic                  b_out_ready,
  output logic [SQRT_OUT_W-1:0] b_out_data,
  output logic                  busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  tag_t                 pipe_q [LAT];
  tag_t                 tag_in_s;
  tag_t                 tag_out_s;
  chan_t                last_q, last_d;
  logic [SQRT_IN_W-1:0] din_q, din_d;
  logic [CW-1:0]        infl_a_q, infl_a_d, infl_b_q, infl_b_d;
  logic [CW-1:0]        cnt_a_s, cnt_b_s;
  logic                 elig_a_s, elig_b_s, grant_a_s, grant_b_s;
  logic                 cap_a_s, cap_b_s, pop_a_s, pop_b_s;

  function automatic logic [CW-1:0] cnt_upd(input logic [CW-1:0] c,
                                            input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return c + CW'(1'b1);
      2'b01:   return c - CW'(1'b1);
      default: return c;
    endcase
  endfunction

  // Credit check and arbitration; only registered state and the valids feed ready
  always_comb begin
    elig_a_s  = a_valid && (({1'b0, cnt_a_s} + {1'b0, infl_a_q}) < DEPTH_W);
    elig_b_s  = b_valid && (({1'b0, cnt_b_s} + {1'b0, infl_b_q}) < DEPTH_W);
    grant_a_s = reset && elig_a_s && (!elig_b_s || (last_q == CH_B));
    grant_b_s = reset && elig_b_s && (!elig_a_s || (last_q == CH_A));
    a_ready   = grant_a_s;
    b_ready   = grant_b_s;
    tag_out_s = pipe_q[LAT-1];
    cap_a_s   = tag_out_s.valid && (tag_out_s.chan == CH_A);
    cap_b_s   = tag_out_s.valid && (tag_out_s.chan == CH_B);
    pop_a_s   = a_out_valid && a_out_ready;
    pop_b_s   = b_out_valid && b_out_ready;
  end

  // Issue next-state: operand register, tag entry, last-grant and in-flight counts
  always_comb begin
    last_d   = last_q;
    din_d    = din_q;
    tag_in_s = TAG_IDLE;
    if (grant_a_s) begin
      last_d   = CH_A;
      din_d    = a_data;
      tag_in_s = '{valid: 1'b1, chan: CH_A};
    end else if (grant_b_s) begin
      last_d   = CH_B;
      din_d    = b_data;
      tag_in_s = '{valid: 1'b1, chan: CH_B};
    end else begin
      last_d   = last_q;
      din_d    = din_q;
    end
    infl_a_d = cnt_upd(infl_a_q, grant_a_s, cap_a_s);
    infl_b_d = cnt_upd(infl_b_q, grant_b_s, cap_b_s);
  end

  // State registers and the tag shift pipe matching the unit latency
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_q   <= CH_B;
      din_q    <= '0;
      infl_a_q <= '0;
      infl_b_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= TAG_IDLE;
      end
    end else begin
      last_q    <= last_d;
      din_q     <= din_d;
      infl_a_q  <= infl_a_d;
      infl_b_q  <= infl_b_d;
      pipe_q[0] <= tag_in_s;
      for (int i = 1; i < LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  sqrt_resp_fifo #(.DEPTH(DEPTH), .W(SQRT_OUT_W)) u_fifo_a (
    .clock       (clock),
    .reset       (reset),
    .push_i      (cap_a_s),
    .push_data_i (sq_dout),
    .pop_i       (pop_a_s),
    .out_valid_o (a_out_valid),
    .out_data_o  (a_out_data),
    .count_o     (cnt_a_s)
  );

  sqrt_resp_fifo #(.DEPTH(DEPTH), .W(SQRT_OUT_W)) u_fifo_b (
    .clock       (clock),
    .reset       (reset),
    .push_i      (cap_b_s),
    .push_data_i (sq_dout),
    .pop_i       (pop_b_s),
    .out_valid_o (b_out_valid),
    .out_data_o  (b_out_data),
    .count_o     (cnt_b_s)
  );

  assign sq_din = din_q;
  assign busy   = (infl_a_q != '0) || (infl_b_q != '0) || a_out_valid || b_out_valid;

endmodule
